// File: rtl/i2c_pkg.sv
// Shared opcodes, R/W bit values and step encoding for the I2C poll sequencer.
package i2c_pkg;

   localparam logic [1:0] OP_START = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd2;
   localparam logic [1:0] OP_STOP  = 2'd3;

   localparam logic RW_W = 1'b0;
   localparam logic RW_R = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE, ST_START1, ST_WADDR, ST_WREG, ST_START2, ST_RADDR, ST_READ,
      ST_STOP, ST_FIN, ST_ISTART, ST_IADDR, ST_IREG, ST_IVAL
   } step_t;

   typedef enum logic {PH_ISSUE, PH_WAIT} phase_t;

   function automatic logic [1:0] step_op(input step_t s);
      case (s)
         ST_START1, ST_START2, ST_ISTART: return OP_START;
         ST_READ:                         return OP_READ;
         ST_STOP:                         return OP_STOP;
         default:                         return OP_WRITE;
      endcase
   endfunction

   function automatic step_t step_next(input step_t s);
      case (s)
         ST_START1: return ST_WADDR;
         ST_WADDR:  return ST_WREG;
         ST_WREG:   return ST_START2;
         ST_START2: return ST_RADDR;
         ST_RADDR:  return ST_READ;
         ST_READ:   return ST_STOP;
         ST_ISTART: return ST_IADDR;
         ST_IADDR:  return ST_IREG;
         ST_IREG:   return ST_IVAL;
         ST_IVAL:   return ST_STOP;
         ST_STOP:   return ST_FIN;
         default:   return ST_IDLE;
      endcase
   endfunction

   function automatic logic step_is_cmd(input step_t s);
      return (s != ST_IDLE) && (s != ST_FIN);
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with registered rising-edge pulse; pulse appears 3 clocks after the pin edge.
module sync_edge (
   input  logic CLK,
   input  logic reset,
   input  logic in,
   output logic pulse
);

   logic s1, s2, s3;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         s3    <= 1'b0;
         pulse <= 1'b0;
      end else begin
         s1    <= in;
         s2    <= s1;
         s3    <= s2;
         pulse <= s2 & ~s3;
      end
   end

endmodule

// File: rtl/i2c_poll_seq.sv
// I2C poll sequencer: periodic/manual register read onto the LEDs via a byte-engine handshake.
// Optional one-shot config write after reset: define I2C_POLL_INIT_EN.
module i2c_poll_seq
   import i2c_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR    = 7'h48,
   parameter logic [7:0]  RD_REG      = 8'h00,
   parameter int unsigned POLL_CYCLES = 12000000,
   parameter logic [7:0]  INIT_REG    = 8'h01,
   parameter logic [7:0]  INIT_VAL    = 8'h60
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       SW1,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [1:0] cmd_op,
   output logic [7:0] cmd_data,
   output logic       cmd_nack,
   input  logic       rsp_valid,
   input  logic [7:0] rsp_data,
   input  logic       rsp_nack,
   output logic [7:0] leds,
   output logic       busy,
   output logic       err,
   output logic       done
);

   step_t       step_q, step_d;
   phase_t      phase_q, phase_d;
   logic [23:0] timer_q;
   logic        pending_q, nacked_q, got_rd_q, err_q;
   logic [7:0]  hold_q, leds_q;
   logic        trig, poll_req, req, init_pend, rsp_fire;

   sync_edge u_sw1 (.CLK(CLK), .reset(reset), .in(SW1), .pulse(trig));

`ifdef I2C_POLL_INIT_EN
   logic init_q;
   always_ff @(posedge CLK or posedge reset) begin
      if (reset)                  init_q <= 1'b1;
      else if (step_q == ST_IDLE) init_q <= 1'b0;
   end
   assign init_pend = init_q;
`else
   assign init_pend = 1'b0;
`endif

   assign poll_req = (step_q == ST_IDLE) && (timer_q == 24'(POLL_CYCLES - 1));
   assign req      = trig | poll_req | pending_q;
   assign rsp_fire = (phase_q == PH_WAIT) && rsp_valid;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         step_q  <= ST_IDLE;
         phase_q <= PH_ISSUE;
      end else begin
         step_q  <= step_d;
         phase_q <= phase_d;
      end
   end

   always_comb begin
      step_d  = step_q;
      phase_d = phase_q;
      case (step_q)
         ST_IDLE: begin
            phase_d = PH_ISSUE;
            if (init_pend) step_d = ST_ISTART;
            else if (req)  step_d = ST_START1;
         end
         ST_FIN: step_d = ST_IDLE;
         default: begin
            if (phase_q == PH_ISSUE) begin
               if (cmd_ready) phase_d = PH_WAIT;
            end else if (rsp_valid) begin
               phase_d = PH_ISSUE;
               // a NACKed write abandons the rest of the sequence but still releases the bus
               if (step_op(step_q) == OP_WRITE && rsp_nack) step_d = ST_STOP;
               else                                         step_d = step_next(step_q);
            end
         end
      endcase
   end

   always_comb begin
      cmd_valid = 1'b0;
      cmd_op    = OP_START;
      cmd_data  = 8'h00;
      cmd_nack  = 1'b0;
      if (step_is_cmd(step_q) && phase_q == PH_ISSUE) begin
         cmd_valid = 1'b1;
         cmd_op    = step_op(step_q);
         cmd_nack  = (step_q == ST_READ);
         case (step_q)
            ST_WADDR, ST_IADDR: cmd_data = {DEV_ADDR, RW_W};
            ST_RADDR:           cmd_data = {DEV_ADDR, RW_R};
            ST_WREG:            cmd_data = RD_REG;
            ST_IREG:            cmd_data = INIT_REG;
            ST_IVAL:            cmd_data = INIT_VAL;
            default:            cmd_data = 8'h00;
         endcase
      end
      busy = step_is_cmd(step_q);
      done = (step_q == ST_FIN);
      leds = leds_q;
      err  = err_q;
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         timer_q   <= '0;
         pending_q <= 1'b0;
         nacked_q  <= 1'b0;
         got_rd_q  <= 1'b0;
         hold_q    <= 8'h00;
         leds_q    <= 8'h00;
         err_q     <= 1'b0;
      end else begin
         // timer only runs while idle; leaving idle restarts the interval
         if (step_q == ST_IDLE)
            timer_q <= (step_d == ST_IDLE) ? timer_q + 24'd1 : 24'd0;

         if (step_q == ST_IDLE && !init_pend) pending_q <= 1'b0;
         else if (trig || poll_req)           pending_q <= 1'b1;

         if (step_q == ST_IDLE) begin
            nacked_q <= 1'b0;
            got_rd_q <= 1'b0;
         end else if (rsp_fire && rsp_nack && step_op(step_q) == OP_WRITE) begin
            nacked_q <= 1'b1;
         end else if (rsp_fire && step_q == ST_READ) begin
            hold_q   <= rsp_data;
            got_rd_q <= 1'b1;
         end

         if (rsp_fire && step_q == ST_STOP) begin
            err_q <= nacked_q;
            if (got_rd_q && !nacked_q) leds_q <= hold_q;
         end
      end
   end

endmodule

// File: tb/tb_i2c_poll_seq.sv
// Directed bench for i2c_poll_seq with a zero-latency byte-engine model; honours I2C_POLL_INIT_EN.
module tb_i2c_poll_seq;
   import i2c_pkg::*;

   logic       CLK = 1'b0, reset = 1'b1, SW1 = 1'b0;
   logic       cmd_ready = 1'b1, rsp_valid = 1'b0, rsp_nack = 1'b0;
   logic [7:0] rsp_data = 8'h00;
   logic       cmd_valid, cmd_nack, busy, err, done;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data, leds;

   i2c_poll_seq #(.POLL_CYCLES(16)) dut (
      .CLK(CLK), .reset(reset), .SW1(SW1),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_nack(cmd_nack),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
      .leds(leds), .busy(busy), .err(err), .done(done)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0, n_bad = 0, cyc = 0, done_cnt = 0, exp_done = 0;
   int stall_left = 0, stall_n = 0, stall_first = -1, stall_last = -1, stall_logsz = 0;
   logic       pend = 1'b0, pend_nack = 1'b0, nack_en = 1'b0;
   logic [7:0] nack_byte = 8'h90, rd_byte = 8'hA5;
   logic [10:0] log_q[$], exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] mk(input logic [1:0] op, input logic [7:0] d, input logic n);
      return {op, d, n};
   endfunction

   always @(posedge CLK) cyc++;

   // engine model: accept unless stalling WR 00, answer in the following cycle
   always @(negedge CLK) begin
      if (done) done_cnt++;
      if (stall_left > 0 && cmd_valid && cmd_op == OP_WRITE && cmd_data == 8'h00) begin
         cmd_ready = 1'b0;
         stall_left--;
         stall_n++;
         if (stall_first < 0) stall_first = cyc;
         stall_last  = cyc;
         stall_logsz = log_q.size();
      end else begin
         cmd_ready = 1'b1;
      end
      if (cmd_valid && cmd_ready) begin
         log_q.push_back({cmd_op, cmd_data, cmd_nack});
         pend      = 1'b1;
         pend_nack = nack_en && cmd_op == OP_WRITE && cmd_data == nack_byte;
      end
   end

   always @(posedge CLK) begin
      #1;
      rsp_valid = pend;
      rsp_nack  = pend & pend_nack;
      rsp_data  = pend ? rd_byte : 8'h00;
      pend      = 1'b0;
   end

   task automatic wait_done(input string tag, input int max);
      int k = 0;
      do begin @(negedge CLK); k++; end while (!done && k < max);
      chk(tag, 32'(done), 32'd1);
      if (done) exp_done++;
   endtask

   task automatic wait_cmd(input string tag, input int max, output int n);
      int k = 0;
      do begin @(negedge CLK); k++; end while (!cmd_valid && k < max);
      chk(tag, 32'(cmd_valid), 32'd1);
      n = k;
   endtask

   task automatic chk_log(input string tag);
      chk($sformatf("%s_len", tag), 32'(log_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
      log_q.delete();
   endtask

   task automatic exp_read();
      exp_q.delete();
      exp_q.push_back(mk(OP_START, 8'h00, 1'b0));
      exp_q.push_back(mk(OP_WRITE, 8'h90, 1'b0));
      exp_q.push_back(mk(OP_WRITE, 8'h00, 1'b0));
      exp_q.push_back(mk(OP_START, 8'h00, 1'b0));
      exp_q.push_back(mk(OP_WRITE, 8'h91, 1'b0));
      exp_q.push_back(mk(OP_READ,  8'h00, 1'b1));
      exp_q.push_back(mk(OP_STOP,  8'h00, 1'b0));
   endtask

   task automatic exp_init();
      exp_q.delete();
      exp_q.push_back(mk(OP_START, 8'h00, 1'b0));
      exp_q.push_back(mk(OP_WRITE, 8'h90, 1'b0));
      exp_q.push_back(mk(OP_WRITE, 8'h01, 1'b0));
      exp_q.push_back(mk(OP_WRITE, 8'h60, 1'b0));
      exp_q.push_back(mk(OP_STOP,  8'h00, 1'b0));
   endtask

   task automatic chk_rst_vals(input string tag);
      chk({tag, "_valid"}, 32'(cmd_valid), 32'd0);
      chk({tag, "_op"},    32'(cmd_op),    32'd0);
      chk({tag, "_data"},  32'(cmd_data),  32'd0);
      chk({tag, "_nack"},  32'(cmd_nack),  32'd0);
      chk({tag, "_leds"},  32'(leds),      32'd0);
      chk({tag, "_busy"},  32'(busy),      32'd0);
      chk({tag, "_err"},   32'(err),       32'd0);
      chk({tag, "_done"},  32'(done),      32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, c0, extra;
      repeat (3) @(negedge CLK);
      chk_rst_vals("rst");
      reset = 1'b0;

      // first automatic poll
`ifdef I2C_POLL_INIT_EN
      wait_done("init_done", 60);
      exp_init();
      chk_log("init");
      chk("init_err", 32'(err), 32'd0);
      wait_cmd("poll_seen", 60, k);
      chk("poll_lat", 32'(k), 32'd17);
`else
      wait_cmd("poll_seen", 60, k);
      chk("poll_lat", 32'(k), 32'd16);
`endif
      c0 = cyc;
      wait_done("poll_done", 40);
      chk("txn_len", 32'(cyc - c0), 32'd14);
      chk("poll_busy_fin", 32'(busy), 32'd0);
      exp_read();
      chk_log("poll");
      chk("poll_leds", 32'(leds), 32'hA5);
      chk("poll_err", 32'(err), 32'd0);
      @(negedge CLK);
      chk("poll_done_pulse", 32'(done), 32'd0);
      chk("poll_done_cnt", 32'(done_cnt), 32'(exp_done));

      // slave NACKs the address byte
      nack_en = 1'b1;
      wait_done("nack_done", 60);
      nack_en = 1'b0;
      exp_q.delete();
      exp_q.push_back(mk(OP_START, 8'h00, 1'b0));
      exp_q.push_back(mk(OP_WRITE, 8'h90, 1'b0));
      exp_q.push_back(mk(OP_STOP,  8'h00, 1'b0));
      chk_log("nack");
      chk("nack_err", 32'(err), 32'd1);
      chk("nack_leds", 32'(leds), 32'hA5);

      // clean poll afterwards
      rd_byte = 8'h3C;
      wait_done("clean_done", 60);
      exp_read();
      chk_log("clean");
      chk("clean_err", 32'(err), 32'd0);
      chk("clean_leds", 32'(leds), 32'h3C);

      // engine stalls WR 00 for 5 cycles
      rd_byte = 8'h77;
      stall_left = 5;
      wait_done("stall_done", 80);
      chk("stall_cycles", 32'(stall_n), 32'd5);
      chk("stall_span", 32'(stall_last - stall_first), 32'd4);
      chk("stall_logsz", 32'(stall_logsz), 32'd2);
      exp_read();
      chk_log("stall");
      chk("stall_leds", 32'(leds), 32'h77);

      // SW1 press mid-idle
      rd_byte = 8'h5A;
      @(posedge CLK);
      #1 SW1 = 1'b1;
      repeat (4) @(negedge CLK);
      chk("sw_early", 32'(cmd_valid), 32'd0);
      @(negedge CLK);
      chk("sw_lat", 32'(cmd_valid), 32'd1);
      chk("sw_leds_before", 32'(leds), 32'h77);
      SW1 = 1'b0;
      wait_done("sw_done", 40);
      exp_read();
      chk_log("sw");
      chk("sw_leds", 32'(leds), 32'h5A);

      // three presses during a transaction collapse into one follow-up
      wait_cmd("tg_start", 40, k);
      repeat (3) begin
         SW1 = 1'b1; repeat (2) @(negedge CLK);
         SW1 = 1'b0; repeat (2) @(negedge CLK);
      end
      wait_done("tg_done1", 40);
      @(negedge CLK);
      chk("tg_gap", 32'(cmd_valid), 32'd0);
      @(negedge CLK);
      chk("tg_extra", 32'(cmd_valid), 32'd1);
      wait_done("tg_done2", 40);
      extra = 0;
      repeat (10) begin
         @(negedge CLK);
         if (cmd_valid) extra++;
      end
      chk("tg_no_third", 32'(extra), 32'd0);
      chk("tg_done_cnt", 32'(done_cnt), 32'(exp_done));
      log_q.delete();

      // reset while waiting for the READ response
      k = 0;
      do begin @(negedge CLK); k++; end while (!(cmd_valid && cmd_op == OP_READ) && k < 60);
      chk("mid_read_seen", 32'(cmd_valid && cmd_op == OP_READ), 32'd1);
      @(negedge CLK);
      chk("mid_busy", 32'(busy), 32'd1);
      #1 reset = 1'b1;
      #1 chk_rst_vals("mid_rst");
      pend = 1'b0;
      repeat (2) @(negedge CLK);
      reset = 1'b0;
      log_q.delete();
      rd_byte = 8'hC3;
`ifdef I2C_POLL_INIT_EN
      wait_done("rst_init_done", 60);
      exp_init();
      chk_log("rst_init");
`endif
      wait_done("rst_poll_done", 60);
      exp_read();
      chk_log("rst_poll");
      chk("rst_poll_leds", 32'(leds), 32'hC3);
      chk("rst_poll_err", 32'(err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
